mux_sel_arbiter: RTL

//   Upstream control stage for the 2:1 data muxes. It arbitrates between two

---
 rtl/mux_sel_arbiter_pkg.sv | 24 ++
 rtl/mux_hold_cnt.sv | 34 +++
 rtl/mux_sel_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the two-source mux select arbiter.
// Holds the FSM state encoding and small grant-decode helpers.
// No logic of its own; imported by the top and the dwell counter.
package mux_sel_arbiter_pkg;

    // FSM state encoding; 2'd3 is unreachable and recovers to idle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G0   = 2'd1,
        ST_G1   = 2'd2,
        ST_ILL  = 2'd3
    } state_t;

    // Source that wins a simultaneous request from idle: the one not served last
    function automatic state_t tie_winner(input logic last);
        return last ? ST_G0 : ST_G1;
    endfunction

    // True for the two states that own the mux path
    function automatic logic is_grant(input state_t st);
        return (st == ST_G0) || (st == ST_G1);
    endfunction

endpackage

// File: rtl/mux_hold_cnt.sv
// Dwell counter: counts consecutive cycles a grant is held, saturating at MAX_HOLD-1.
// Latency: clr/inc take effect on the next rising edge; at_max is decoded from the register.
// Backpressure: none; clr has priority over inc and the count never wraps.
module mux_hold_cnt
    import mux_sel_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt;

    assign at_max = (cnt == CNT_TOP);

    // Clear on every state change, otherwise count up and stick at the top value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for two requesters with bounded dwell; drives mux sel and one-hot grants.
// Latency: one cycle from sampled request to registered grant; no comb path req -> outputs.
// Backpressure: a holder is preempted after MAX_HOLD cycles if the other side requests.
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic sel,
    output logic gnt0,
    output logic gnt1,
    output logic busy
);

    state_t state;
    state_t nxt;
    logic   last;
    logic   at_max;
    logic   cnt_clr;
    logic   cnt_inc;

    // Next-state decision from the current owner, requests and dwell limit
    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    nxt = tie_winner(last);
                end else if (req0) begin
                    nxt = ST_G0;
                end else if (req1) begin
                    nxt = ST_G1;
                end else begin
                    nxt = ST_IDLE;
                end
            end
            ST_G0: begin
                if (!req0) begin
                    nxt = req1 ? ST_G1 : ST_IDLE;
                end else if (req1 && at_max) begin
                    nxt = ST_G1;
                end else begin
                    nxt = ST_G0;
                end
            end
            ST_G1: begin
                if (!req1) begin
                    nxt = req0 ? ST_G0 : ST_IDLE;
                end else if (req0 && at_max) begin
                    nxt = ST_G0;
                end else begin
                    nxt = ST_G1;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Dwell restarts on any change of owner, and is held at zero while idle
    always_comb begin
        cnt_clr = (nxt != state) || !is_grant(nxt);
        cnt_inc = !cnt_clr;
    end

    mux_hold_cnt #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .at_max (at_max)
    );

    // State, round-robin pointer and registered outputs; sel only moves on grant entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            last  <= 1'b1;
            sel   <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= nxt;
            gnt0  <= (nxt == ST_G0);
            gnt1  <= (nxt == ST_G1);
            busy  <= is_grant(nxt);
            if (nxt == ST_G0) begin
                sel  <= 1'b0;
                last <= 1'b0;
            end else if (nxt == ST_G1) begin
                sel  <= 1'b1;
                last <= 1'b1;
            end
        end
    end

endmodule
